// File: rtl/pcie_fc_credit_mon.sv
// PCIe flow-control credit monitor: sweeps cfg_fc_sel modes and samples the six credit fields per mode.
// Optional macro PCIE_FC_MON_ZERO_CNT_EN adds a per-mode count of samples that had any zero field.
module pcie_fc_credit_mon #(
  parameter int          FC_SEL_COUNT = 2,
  parameter logic [23:0] FC_SEL_LIST  = 24'b100_000,
  parameter int          SEL_DWELL    = 4,
  parameter int          CNT_WIDTH    = 32,
  localparam int         IDX_W        = (FC_SEL_COUNT > 1) ? $clog2(FC_SEL_COUNT) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  input  logic [7:0]       cfg_fc_ph,
  input  logic [7:0]       cfg_fc_nph,
  input  logic [7:0]       cfg_fc_cplh,
  input  logic [11:0]      cfg_fc_pd,
  input  logic [11:0]      cfg_fc_npd,
  input  logic [11:0]      cfg_fc_cpld,
  output logic [2:0]       cfg_fc_sel,
  output logic             sample_valid,
  output logic [IDX_W-1:0] sample_idx,
  input  logic             reg_rd_en,
  input  logic [IDX_W+3:0] reg_rd_addr,
  output logic [31:0]      reg_rd_data,
  output logic             reg_rd_ack
);

  typedef enum logic [2:0] {IDLE, SET, DWELL, SAMPLE, NEXT} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [7:0]           DWELL_LOAD = 8'(SEL_DWELL - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [7:0]       dwell;
  logic [2:0]       next_sel;
  logic             do_sample;
  logic [11:0]      cap [6];

  logic [11:0]          cur_q [FC_SEL_COUNT][6];
  logic [11:0]          min_q [FC_SEL_COUNT][6];
  logic [CNT_WIDTH-1:0] cnt_q [FC_SEL_COUNT];

  logic [IDX_W-1:0] rd_idx;
  logic [2:0]       rd_field;
  logic             rd_kind;
  logic [31:0]      rd_val;

  // Header fields (even slots) are 8 bits wide, so their "no sample yet" minimum is 8'hFF.
  function automatic logic [11:0] min_init(input int f);
    return (f % 2 == 0) ? 12'h0FF : 12'hFFF;
  endfunction

  assign do_sample = (state == SAMPLE);

  always_comb begin
    cap[0] = {4'h0, cfg_fc_ph};
    cap[1] = cfg_fc_pd;
    cap[2] = {4'h0, cfg_fc_nph};
    cap[3] = cfg_fc_npd;
    cap[4] = {4'h0, cfg_fc_cplh};
    cap[5] = cfg_fc_cpld;
  end

  always_comb begin
    next_sel = FC_SEL_LIST[2:0];
    for (int i = 0; i < 8; i++) begin
      if (i == int'(idx)) next_sel = FC_SEL_LIST[i*3 +: 3];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      dwell        <= '0;
      cfg_fc_sel   <= FC_SEL_LIST[2:0];
      sample_valid <= 1'b0;
      sample_idx   <= '0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE: if (enable) state <= SET;
        // Dropping enable before the sample abandons it; idx and cfg_fc_sel are left as they were.
        SET: begin
          if (!enable) begin
            state <= IDLE;
          end else begin
            cfg_fc_sel <= next_sel;
            dwell      <= DWELL_LOAD;
            state      <= DWELL;
          end
        end
        DWELL: begin
          if (!enable)          state <= IDLE;
          else if (dwell == '0) state <= SAMPLE;
          else                  dwell <= dwell - 8'd1;
        end
        SAMPLE: begin
          sample_valid <= 1'b1;
          sample_idx   <= idx;
          state        <= NEXT;
        end
        NEXT: begin
          idx   <= (idx == IDX_W'(FC_SEL_COUNT - 1)) ? '0 : idx + 1'b1;
          state <= enable ? SET : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A clear landing on the SAMPLE cycle wipes history first, so that sample becomes the new baseline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FC_SEL_COUNT; i++) begin
        for (int f = 0; f < 6; f++) begin
          cur_q[i][f] <= '0;
          min_q[i][f] <= min_init(f);
        end
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < FC_SEL_COUNT; i++) begin
        if (do_sample && int'(idx) == i) begin
          for (int f = 0; f < 6; f++) begin
            cur_q[i][f] <= cap[f];
            min_q[i][f] <= (clear || cap[f] < min_q[i][f]) ? cap[f] : min_q[i][f];
          end
          if (clear)                 cnt_q[i] <= CNT_ONE;
          else if (cnt_q[i] != CNT_MAX) cnt_q[i] <= cnt_q[i] + 1'b1;
        end else if (clear) begin
          for (int f = 0; f < 6; f++) min_q[i][f] <= min_init(f);
          cnt_q[i] <= '0;
        end
      end
    end
  end

`ifdef PCIE_FC_MON_ZERO_CNT_EN
  logic [CNT_WIDTH-1:0] zcnt_q [FC_SEL_COUNT];
  logic                 any_zero;

  always_comb begin
    any_zero = 1'b0;
    for (int f = 0; f < 6; f++) begin
      if (cap[f] == 12'h000) any_zero = 1'b1;
    end
  end

  // Same clear-then-sample ordering as the sample counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FC_SEL_COUNT; i++) zcnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < FC_SEL_COUNT; i++) begin
        if (do_sample && int'(idx) == i) begin
          if (clear)                                zcnt_q[i] <= any_zero ? CNT_ONE : '0;
          else if (any_zero && zcnt_q[i] != CNT_MAX) zcnt_q[i] <= zcnt_q[i] + 1'b1;
        end else if (clear) begin
          zcnt_q[i] <= '0;
        end
      end
    end
  end
`endif

  assign rd_idx   = reg_rd_addr[IDX_W+3:4];
  assign rd_field = reg_rd_addr[3:1];
  assign rd_kind  = reg_rd_addr[0];

  always_comb begin
    rd_val = '0;
    if (int'(rd_idx) < FC_SEL_COUNT) begin
      if (rd_field <= 3'd5) begin
        rd_val = {20'h0, rd_kind ? min_q[rd_idx][rd_field] : cur_q[rd_idx][rd_field]};
      end else if (rd_field == 3'd6) begin
        if (!rd_kind) rd_val = 32'(cnt_q[rd_idx]);
      end else begin
`ifdef PCIE_FC_MON_ZERO_CNT_EN
        if (!rd_kind) rd_val = 32'(zcnt_q[rd_idx]);
`endif
      end
    end
  end

  // Read data is registered from pre-edge storage, so a read during SAMPLE sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_rd_data <= '0;
      reg_rd_ack  <= 1'b0;
    end else begin
      reg_rd_ack <= reg_rd_en;
      if (reg_rd_en) reg_rd_data <= rd_val;
    end
  end

endmodule
